seg_dynamic: RTL and testbench

- Six-digit multiplexed (dynamic-scan) seven-segment display driver for a common-anode display.
- Converts a 20-bit unsigned binary value to six BCD digits, with:
  - leading-zero blanking,
  - per-digit decimal points,
  - an optional minus sign.
- Time-multiplexes the digits onto one shared segment bus with one-hot digit select.
- Sits between application logic and the board-level display (or a serial shift-out stage).

---
 rtl/seg_dynamic.sv | 200 ++++++++++++++++++++
 tb/tb_seg_dynamic.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_dynamic.sv
`default_nettype none
// ============================================================================
// Module   : seg_dynamic
// Brief    : Six-digit multiplexed 7-segment driver (common anode) with
//            binary-to-BCD conversion, blanking, decimal points and sign.
// Revision : 1.0  initial release
// ============================================================================
module seg_dynamic #(
    parameter int CNT_MAX = 49999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        seg_en,
    input  logic        sign,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam logic [19:0] DATA_MAX  = 20'd999999;
    localparam logic [15:0] CNT_LAST  = 16'(CNT_MAX);
    localparam logic [4:0]  SHIFT_END = 5'd19;
    localparam logic [2:0]  IDX_LAST  = 3'd5;
    localparam logic [6:0]  PAT_MINUS = 7'h3F;
    localparam logic [6:0]  PAT_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } conv_state_e;

    // ------------------------------------------------------------------
    // Binary to BCD (double dabble)
    // ------------------------------------------------------------------
    conv_state_e state_q;
    logic [19:0] bin_q;
    logic [23:0] work_q;
    logic [4:0]  shcnt_q;
    logic [23:0] bcd_q;

    logic [19:0] data_clamped;
    logic [23:0] work_adj;

    function automatic logic [23:0] add3(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < 6; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign data_clamped = (data > DATA_MAX) ? DATA_MAX : data;
    assign work_adj     = add3(work_q);

    // One load, twenty shifts and one latch: 22 clocks per conversion.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_LOAD;
            bin_q   <= 20'd0;
            work_q  <= 24'd0;
            shcnt_q <= 5'd0;
            bcd_q   <= 24'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    bin_q   <= data_clamped;
                    work_q  <= 24'd0;
                    shcnt_q <= 5'd0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    work_q  <= {work_adj[22:0], bin_q[19]};
                    bin_q   <= {bin_q[18:0], 1'b0};
                    shcnt_q <= shcnt_q + 5'd1;
                    if (shcnt_q == SHIFT_END) begin
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    bcd_q   <= work_q;
                    state_q <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        cnt_wrap;

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= 16'd0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit content and segment encoding
    // ------------------------------------------------------------------
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = PAT_BLANK;
        endcase
        return p;
    endfunction

    logic [2:0] hi_nz;
    logic [2:0] hi_pt;
    logic [2:0] msd;
    logic [3:0] digit;
    logic       shown;
    logic [6:0] pat;
    logic [5:0] sel_d;
    logic [7:0] seg_d;

    // A missing point (P = -1) never exceeds H, so treating it as 0 is exact.
    always_comb begin
        hi_nz = 3'd0;
        hi_pt = 3'd0;
        for (int i = 1; i < 6; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                hi_nz = 3'(i);
            end
            if (point[i]) begin
                hi_pt = 3'(i);
            end
        end
        msd   = (hi_pt > hi_nz) ? hi_pt : hi_nz;
        digit = bcd_q[{idx_q, 2'b00} +: 4];
        shown = 1'b0;
        pat   = PAT_BLANK;
        if (idx_q <= msd) begin
            shown = 1'b1;
            pat   = enc(digit);
        end else if (sign && (idx_q == msd + 3'd1)) begin
            pat   = PAT_MINUS;
        end
        if (seg_en) begin
            sel_d = 6'b000001 << idx_q;
            seg_d = {~(shown & point[idx_q]), pat};
        end else begin
            sel_d = 6'b000000;
            seg_d = 8'hFF;
        end
    end

    // sel and seg share one register stage so they always switch together.
    logic [5:0] sel_q;
    logic [7:0] seg_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_q <= 6'b000000;
            seg_q <= 8'hFF;
        end else begin
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_dynamic.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_dynamic
// Brief    : Scoreboard bench for seg_dynamic with a shortened scan dwell.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_dynamic;

    localparam int CNT_MAX = 19;
    localparam int DWELL   = CNT_MAX + 1;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [19:0] data;
    logic [5:0]  point;
    logic        seg_en;
    logic        sign;
    logic [5:0]  sel;
    logic [7:0]  seg;

    seg_dynamic #(.CNT_MAX(CNT_MAX)) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .point     (point),
        .seg_en    (seg_en),
        .sign      (sign),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [13:0] exp_q[$];

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got sel=%b seg=%h, want sel=%b seg=%h",
                     tag, obs[13:8], obs[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic push(input logic [5:0] s, input logic [7:0] p);
        exp_q.push_back({s, p});
    endtask

    task automatic pop_chk(input string tag);
        logic [13:0] e;
        e = exp_q.pop_front();
        chk(tag, {sel, seg}, e);
    endtask

    // pats[8k+7:8k] is the expected pattern of digit k
    task automatic push_frame(input logic [47:0] pats);
        for (int k = 0; k < 6; k++) begin
            push(6'b000001 << k, pats[8*k +: 8]);
        end
    endtask

    task automatic run_frame(input string tag);
        logic [5:0] prev;
        logic       ok;
        ok = 1'b0;
        @(negedge sys_clk);
        prev = sel;
        for (int i = 0; i < 12 * DWELL + 20; i++) begin
            @(negedge sys_clk);
            if (sel == 6'b000001 && prev != 6'b000001) begin
                ok = 1'b1;
                break;
            end
            prev = sel;
        end
        chk({tag, " sync"}, {13'd0, ok}, 14'd1);
        for (int k = 0; k < 6; k++) begin
            pop_chk($sformatf("%s d%0d", tag, k));
            repeat (DWELL) @(negedge sys_clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        data   = 20'd9876;
        point  = 6'b000000;
        sign   = 1'b0;
        seg_en = 1'b0;

        #1 sys_rst_n = 1'b0;
        #1;
        push(6'b000000, 8'hFF);
        pop_chk("rst-async");
        repeat (3) @(negedge sys_clk);
        push(6'b000000, 8'hFF);
        pop_chk("rst-held");
        sys_rst_n = 1'b1;

        for (int i = 0; i < 7 * 6 * DWELL / 10; i++) begin
            repeat (10) @(negedge sys_clk);
            push(6'b000000, 8'hFF);
            pop_chk($sformatf("en-off %0d", i));
        end

        seg_en = 1'b1;
        point  = 6'b000010;
        sign   = 1'b1;
        repeat (50) @(negedge sys_clk);
        push_frame(48'hFF_BF_90_80_78_82);
        run_frame("9876");

        data  = 20'd5;
        point = 6'b000100;
        sign  = 1'b0;
        repeat (50) @(negedge sys_clk);
        push_frame(48'hFF_FF_FF_40_C0_92);
        run_frame("5-dp2");

        data  = 20'd0;
        point = 6'b000000;
        sign  = 1'b1;
        repeat (50) @(negedge sys_clk);
        push_frame(48'hFF_FF_FF_FF_BF_C0);
        run_frame("zero-neg");

        data = 20'd1048575;
        repeat (50) @(negedge sys_clk);
        push_frame(48'h90_90_90_90_90_90);
        run_frame("clamp");

        // run_frame leaves us at the first cycle of digit 0; move into digit 2
        repeat (2 * DWELL + 5) @(negedge sys_clk);
        seg_en = 1'b0;
        @(negedge sys_clk);
        push(6'b000000, 8'hFF);
        pop_chk("en-drop");
        repeat (2) @(negedge sys_clk);
        push(6'b000000, 8'hFF);
        pop_chk("en-low");
        seg_en = 1'b1;
        @(negedge sys_clk);
        push(6'b000100, 8'h90);
        pop_chk("en-resume");

        data = 20'd123456;
        repeat (50) @(negedge sys_clk);
        repeat (DWELL / 2) @(negedge sys_clk);
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1;
        push(6'b000000, 8'hFF);
        pop_chk("rst-mid");
        repeat (2) @(negedge sys_clk);
        push(6'b000000, 8'hFF);
        pop_chk("rst-mid-held");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        push(6'b000001, 8'hC0);
        pop_chk("post-rst-d0");
        repeat (DWELL + 44) @(negedge sys_clk);
        push_frame(48'hF9_A4_B0_99_92_82);
        run_frame("after-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
